// File: rtl/pause_halt_ctrl.sv
// pause_halt_ctrl: arbitrates the core's single halt input between the user
// pause button, OSD-open pause and hiscore RAM access.
//
// Halts only on a vblank rising edge (or after VB_TIMEOUT cycles), lets the
// halt settle for HALT_SETTLE cycles before granting hiscore access, and on
// release drops hs_grant at least one cycle before cpu_pause. A long
// user/OSD pause raises dim_video.
//
// Ports:
//   clk_sys      in  system clock
//   reset        in  asynchronous active-high reset
//   btn_pause    in  pause button level (clk_sys domain)
//   osd_open     in  OSD visible
//   osd_pause_en in  pause while OSD is open
//   hs_req       in  hiscore RAM access request (level)
//   vblank       in  core vertical blank
//   cpu_pause    out halt to core (registered)
//   hs_grant     out hiscore may access RAM (registered)
//   user_paused  out user pause toggle state
//   dim_video    out dim output video (registered)

module pause_halt_ctrl #(
    parameter int unsigned      CNT_W       = 32,
    parameter logic [CNT_W-1:0] DIM_CYCLES  = 32'h1C9C3800,
    parameter int unsigned      HALT_SETTLE = 4,
    parameter logic [CNT_W-1:0] VB_TIMEOUT  = 32'h000F4240
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic btn_pause,
    input  logic osd_open,
    input  logic osd_pause_en,
    input  logic hs_req,
    input  logic vblank,
    output logic cpu_pause,
    output logic hs_grant,
    output logic user_paused,
    output logic dim_video
);

    localparam int unsigned SW =
        (HALT_SETTLE > 1) ? $clog2(HALT_SETTLE) : 1;

    localparam logic [SW-1:0]    SETTLE_LAST = SW'(HALT_SETTLE - 1);
    localparam logic [CNT_W-1:0] TO_LAST     = VB_TIMEOUT - CNT_W'(1);

    localparam logic [2:0] S_RUN     = 3'd0;
    localparam logic [2:0] S_WAIT_VB = 3'd1;
    localparam logic [2:0] S_HALT    = 3'd2;
    localparam logic [2:0] S_HELD    = 3'd3;
    localparam logic [2:0] S_RELEASE = 3'd4;

    logic [2:0]       state;
    logic [2:0]       state_nx;
    logic             btn_q;
    logic             vb_q;
    logic             btn_rise;
    logic             vb_rise;
    logic             view_pause;
    logic             halt_want;
    logic [CNT_W-1:0] to_cnt;
    logic [SW-1:0]    settle_cnt;
    logic [CNT_W-1:0] dim_cnt;
    logic [CNT_W-1:0] dim_nx;
    logic             pause_nx;

    always_comb begin
        btn_rise   = btn_pause & ~btn_q;
        vb_rise    = vblank & ~vb_q;
        view_pause = user_paused | (osd_open & osd_pause_en);
        halt_want  = view_pause | hs_req;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_RUN: begin
                if (halt_want)
                    state_nx = S_WAIT_VB;
            end
            S_WAIT_VB: begin
                if (!halt_want)
                    state_nx = S_RUN;
                else if (vb_rise || to_cnt == TO_LAST)
                    state_nx = S_HALT;
            end
            S_HALT: begin
                // Settle always completes, even if the request went away.
                if (settle_cnt == SETTLE_LAST)
                    state_nx = S_HELD;
            end
            S_HELD: begin
                if (!halt_want)
                    state_nx = S_RELEASE;
            end
            S_RELEASE: begin
                // One cycle of pause with grant already low; a new
                // request re-enters through WAIT_VB.
                state_nx = S_RUN;
            end
            default: state_nx = S_RUN;
        endcase
    end

    always_comb begin
        pause_nx = (state_nx == S_HALT) ||
                   (state_nx == S_HELD) ||
                   (state_nx == S_RELEASE);
    end

    // Dim counter runs only while the core is actually halted for a
    // viewer-visible reason; hiscore-only halts never dim the picture.
    always_comb begin
        dim_nx = '0;
        if (cpu_pause && view_pause) begin
            if (dim_cnt >= DIM_CYCLES)
                dim_nx = dim_cnt;
            else
                dim_nx = dim_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state       <= S_RUN;
            btn_q       <= 1'b0;
            vb_q        <= 1'b0;
            user_paused <= 1'b0;
            to_cnt      <= '0;
            settle_cnt  <= '0;
            dim_cnt     <= '0;
            cpu_pause   <= 1'b0;
            hs_grant    <= 1'b0;
            dim_video   <= 1'b0;
        end else begin
            btn_q <= btn_pause;
            vb_q  <= vblank;
            if (btn_rise)
                user_paused <= ~user_paused;

            state <= state_nx;

            if (state == S_RUN)
                to_cnt <= '0;
            else if (state == S_WAIT_VB && to_cnt != '1)
                to_cnt <= to_cnt + CNT_W'(1);

            if (state == S_WAIT_VB)
                settle_cnt <= '0;
            else if (state == S_HALT && settle_cnt != SETTLE_LAST)
                settle_cnt <= settle_cnt + SW'(1);

            cpu_pause <= pause_nx;
            // Grant tracks hs_req one cycle late, only while fully held.
            hs_grant  <= (state == S_HELD) && hs_req;

            dim_cnt   <= dim_nx;
            dim_video <= (dim_nx >= DIM_CYCLES);
        end
    end

endmodule

// File: tb/tb_pause_halt_ctrl.sv
// tb_pause_halt_ctrl: scenario tasks for pause_halt_ctrl plus a random soak
// checked against a cycle-count / parity model of the halt rules.

module tb_pause_halt_ctrl;

    localparam int DIM = 100;
    localparam int HS  = 4;
    localparam int VBT = 1000;

    logic clk_sys = 1'b0;
    logic reset = 1'b1;
    logic btn_pause = 1'b0;
    logic osd_open = 1'b0;
    logic osd_pause_en = 1'b0;
    logic hs_req = 1'b0;
    logic vblank = 1'b0;
    logic cpu_pause;
    logic hs_grant;
    logic user_paused;
    logic dim_video;

    int tests = 0;
    int fails = 0;

    pause_halt_ctrl #(
        .CNT_W(32),
        .DIM_CYCLES(32'(DIM)),
        .HALT_SETTLE(HS),
        .VB_TIMEOUT(32'(VBT))
    ) dut (
        .clk_sys(clk_sys),
        .reset(reset),
        .btn_pause(btn_pause),
        .osd_open(osd_open),
        .osd_pause_en(osd_pause_en),
        .hs_req(hs_req),
        .vblank(vblank),
        .cpu_pause(cpu_pause),
        .hs_grant(hs_grant),
        .user_paused(user_paused),
        .dim_video(dim_video)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic apply_reset();
        btn_pause = 0; osd_open = 0; osd_pause_en = 0;
        hs_req = 0; vblank = 0;
        reset = 1;
        repeat (2) tick();
        reset = 0;
        tick();
    endtask

    task automatic test_reset();
        btn_pause = 0; osd_open = 0; osd_pause_en = 0;
        hs_req = 0; vblank = 0;
        reset = 1;
        repeat (3) tick();
        tests++;
        if (cpu_pause !== 1'b0) begin
            fails++; $display("FAIL rst_pause got=%b exp=0", cpu_pause);
        end
        tests++;
        if (hs_grant !== 1'b0) begin
            fails++; $display("FAIL rst_grant got=%b exp=0", hs_grant);
        end
        tests++;
        if (user_paused !== 1'b0) begin
            fails++; $display("FAIL rst_user got=%b exp=0", user_paused);
        end
        tests++;
        if (dim_video !== 1'b0) begin
            fails++; $display("FAIL rst_dim got=%b exp=0", dim_video);
        end
        reset = 0;
        repeat (5) tick();
        tests++;
        if (cpu_pause !== 1'b0) begin
            fails++; $display("FAIL idle_pause got=%b exp=0", cpu_pause);
        end
    endtask

    task automatic test_hiscore();
        int d;
        int hold;
        int bad;
        apply_reset();
        d = $urandom_range(20, 80);
        hs_req = 1;
        repeat (d) tick();
        tests++;
        if (cpu_pause !== 1'b0) begin
            fails++; $display("FAIL hs_prevb got=%b exp=0", cpu_pause);
        end
        vblank = 1;
        tick();
        tests++;
        if (cpu_pause !== 1'b1 || hs_grant !== 1'b0) begin
            fails++;
            $display("FAIL hs_halt1 pause=%b grant=%b exp=1,0",
                     cpu_pause, hs_grant);
        end
        vblank = 0;
        bad = 0;
        for (int k = 2; k <= 5; k++) begin
            tick();
            if (hs_grant !== 1'b0 || cpu_pause !== 1'b1) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++; $display("FAIL hs_settle bad=%0d exp=0", bad);
        end
        tick();
        tests++;
        if (hs_grant !== 1'b1 || cpu_pause !== 1'b1) begin
            fails++;
            $display("FAIL hs_grant6 grant=%b pause=%b exp=1,1",
                     hs_grant, cpu_pause);
        end
        hold = $urandom_range(3, 15);
        bad = 0;
        repeat (hold) begin
            tick();
            if (hs_grant !== 1'b1) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++; $display("FAIL hs_hold bad=%0d exp=0", bad);
        end
        hs_req = 0;
        tick();
        tests++;
        if (hs_grant !== 1'b0 || cpu_pause !== 1'b1) begin
            fails++;
            $display("FAIL hs_rel1 grant=%b pause=%b exp=0,1",
                     hs_grant, cpu_pause);
        end
        tick();
        tests++;
        if (cpu_pause !== 1'b0 || hs_grant !== 1'b0) begin
            fails++;
            $display("FAIL hs_rel2 pause=%b grant=%b exp=0,0",
                     cpu_pause, hs_grant);
        end
    endtask

    task automatic test_timeout();
        int bad;
        apply_reset();
        btn_pause = 1;
        tick();
        btn_pause = 0;
        tests++;
        if (user_paused !== 1'b1) begin
            fails++; $display("FAIL to_toggle got=%b exp=1", user_paused);
        end
        bad = 0;
        repeat (VBT) begin
            tick();
            if (cpu_pause !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++; $display("FAIL to_early bad=%0d exp=0", bad);
        end
        tick();
        tests++;
        if (cpu_pause !== 1'b1) begin
            fails++; $display("FAIL to_halt got=%b exp=1", cpu_pause);
        end
        bad = 0;
        repeat (DIM - 1) begin
            tick();
            if (dim_video !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++; $display("FAIL dim_early bad=%0d exp=0", bad);
        end
        tick();
        tests++;
        if (dim_video !== 1'b1) begin
            fails++; $display("FAIL dim_on got=%b exp=1", dim_video);
        end
        bad = 0;
        repeat (20) begin
            tick();
            if (dim_video !== 1'b1 || hs_grant !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++; $display("FAIL dim_sat bad=%0d exp=0", bad);
        end
        btn_pause = 1;
        tick();
        btn_pause = 0;
        tests++;
        if (user_paused !== 1'b0 || cpu_pause !== 1'b1) begin
            fails++;
            $display("FAIL to_unp user=%b pause=%b exp=0,1",
                     user_paused, cpu_pause);
        end
        tick();
        tests++;
        if (dim_video !== 1'b0 || cpu_pause !== 1'b1) begin
            fails++;
            $display("FAIL to_relc dim=%b pause=%b exp=0,1",
                     dim_video, cpu_pause);
        end
        tick();
        tests++;
        if (cpu_pause !== 1'b0) begin
            fails++; $display("FAIL to_run got=%b exp=0", cpu_pause);
        end
    endtask

    task automatic test_osd();
        int bad;
        int w;
        apply_reset();
        osd_open = 1;
        osd_pause_en = 0;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            vblank = (i % 10) < 3;
            tick();
            if (cpu_pause !== 1'b0) bad++;
        end
        vblank = 0;
        tick();
        tests++;
        if (bad != 0) begin
            fails++; $display("FAIL osd_nopause bad=%0d exp=0", bad);
        end
        osd_pause_en = 1;
        tick();
        w = $urandom_range(5, 30);
        bad = 0;
        repeat (w) begin
            tick();
            if (cpu_pause !== 1'b0) bad++;
        end
        vblank = 1;
        tick();
        tests++;
        if (bad != 0 || cpu_pause !== 1'b1) begin
            fails++;
            $display("FAIL osd_halt pause=%b early=%0d exp=1,0",
                     cpu_pause, bad);
        end
        vblank = 0;
        repeat (6) tick();
        tests++;
        if (cpu_pause !== 1'b1 || hs_grant !== 1'b0) begin
            fails++;
            $display("FAIL osd_held pause=%b grant=%b exp=1,0",
                     cpu_pause, hs_grant);
        end
        osd_open = 0;
        tick();
        tests++;
        if (cpu_pause !== 1'b1) begin
            fails++; $display("FAIL osd_relc got=%b exp=1", cpu_pause);
        end
        tick();
        tests++;
        if (cpu_pause !== 1'b0) begin
            fails++; $display("FAIL osd_run got=%b exp=0", cpu_pause);
        end
        osd_pause_en = 0;
    endtask

    task automatic test_grant_follow();
        int n;
        int bad;
        logic r;
        apply_reset();
        btn_pause = 1;
        tick();
        btn_pause = 0;
        tick();
        vblank = 1;
        tick();
        vblank = 0;
        n = 0;
        bad = 0;
        repeat (5) begin
            tick();
            n++;
            if (cpu_pause !== 1'b1 || dim_video !== (n >= DIM)) bad++;
        end
        for (int i = 0; i < 20; i++) begin
            r = 1'($urandom % 2);
            hs_req = r;
            tick();
            n++;
            tests++;
            if (hs_grant !== r) begin
                fails++;
                $display("FAIL gf_grant cyc=%0d got=%b exp=%b",
                         i, hs_grant, r);
            end
            if (cpu_pause !== 1'b1 || dim_video !== (n >= DIM)) bad++;
        end
        hs_req = 0;
        while (n < DIM + 15) begin
            tick();
            n++;
            if (cpu_pause !== 1'b1 || hs_grant !== 1'b0) bad++;
            if (dim_video !== (n >= DIM)) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++; $display("FAIL gf_track bad=%0d exp=0", bad);
        end
        tests++;
        if (dim_video !== 1'b1) begin
            fails++; $display("FAIL gf_dim got=%b exp=1", dim_video);
        end
        btn_pause = 1;
        tick();
        btn_pause = 0;
        repeat (2) tick();
        tests++;
        if (cpu_pause !== 1'b0 || dim_video !== 1'b0) begin
            fails++;
            $display("FAIL gf_rel pause=%b dim=%b exp=0,0",
                     cpu_pause, dim_video);
        end
    endtask

    task automatic test_abort();
        int bad;
        apply_reset();
        btn_pause = 1;
        tick();
        btn_pause = 0;
        tick();
        bad = 0;
        repeat (10) begin
            tick();
            if (cpu_pause !== 1'b0) bad++;
        end
        btn_pause = 1;
        tick();
        btn_pause = 0;
        tick();
        vblank = 1;
        tick();
        vblank = 0;
        repeat (8) begin
            tick();
            if (cpu_pause !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0 || user_paused !== 1'b0) begin
            fails++;
            $display("FAIL ab_wait bad=%0d user=%b exp=0,0",
                     bad, user_paused);
        end
        hs_req = 1;
        tick();
        repeat (3) tick();
        vblank = 1;
        tick();
        tests++;
        if (cpu_pause !== 1'b1) begin
            fails++; $display("FAIL ab_halt got=%b exp=1", cpu_pause);
        end
        vblank = 0;
        hs_req = 0;
        bad = 0;
        for (int k = 1; k <= HS + 1; k++) begin
            tick();
            if (cpu_pause !== 1'b1 || hs_grant !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++; $display("FAIL ab_settle bad=%0d exp=0", bad);
        end
        tick();
        tests++;
        if (cpu_pause !== 1'b0) begin
            fails++; $display("FAIL ab_run got=%b exp=0", cpu_pause);
        end
    endtask

    task automatic test_reset_mid();
        btn_pause = 1;
        tick();
        btn_pause = 0;
        hs_req = 1;
        tick();
        vblank = 1;
        tick();
        vblank = 0;
        repeat (HS + 1) tick();
        tests++;
        if (hs_grant !== 1'b1 || user_paused !== 1'b1) begin
            fails++;
            $display("FAIL rm_pre grant=%b user=%b exp=1,1",
                     hs_grant, user_paused);
        end
        #2;
        reset = 1;
        #1;
        tests++;
        if ({cpu_pause, hs_grant, user_paused, dim_video} !== 4'b0) begin
            fails++;
            $display("FAIL rm_async outs=%b exp=0000",
                     {cpu_pause, hs_grant, user_paused, dim_video});
        end
        hs_req = 0;
        tick();
        reset = 0;
        repeat (3) tick();
        hs_req = 1;
        tick();
        vblank = 1;
        tick();
        tests++;
        if (cpu_pause !== 1'b1) begin
            fails++; $display("FAIL rm_run got=%b exp=1", cpu_pause);
        end
        vblank = 0;
        hs_req = 0;
    endtask

    task automatic test_random();
        logic mu;
        logic btn_prev;
        logic prev_grant;
        logic hw;
        int quiet;
        apply_reset();
        mu = 0;
        btn_prev = 0;
        prev_grant = 0;
        quiet = 0;
        for (int i = 0; i < 3000; i++) begin
            btn_pause = ($urandom % 64) == 0;
            if ($urandom % 30 == 0) hs_req = ~hs_req;
            if ($urandom % 50 == 0) osd_open = ~osd_open;
            if ($urandom % 80 == 0) osd_pause_en = ~osd_pause_en;
            vblank = (i % 173) < 8;
            hw = mu | (osd_open & osd_pause_en) | hs_req;
            tick();
            quiet = hw ? 0 : quiet + 1;
            if (btn_pause && !btn_prev) mu = ~mu;
            btn_prev = btn_pause;
            tests++;
            if (user_paused !== mu) begin
                fails++;
                $display("FAIL rnd_user cyc=%0d got=%b exp=%b",
                         i, user_paused, mu);
            end
            tests++;
            if (hs_grant && !cpu_pause) begin
                fails++;
                $display("FAIL rnd_order cyc=%0d grant=1 pause=%b exp=1",
                         i, cpu_pause);
            end
            tests++;
            if (prev_grant && !cpu_pause) begin
                fails++;
                $display("FAIL rnd_fall cyc=%0d pause=%b exp=1",
                         i, cpu_pause);
            end
            tests++;
            if (hs_grant && !hs_req) begin
                fails++;
                $display("FAIL rnd_req cyc=%0d grant=1 req=0 exp=0", i);
            end
            if (quiet >= HS + 2) begin
                tests++;
                if (cpu_pause !== 1'b0) begin
                    fails++;
                    $display("FAIL rnd_idle cyc=%0d got=%b exp=0",
                             i, cpu_pause);
                end
            end
            prev_grant = hs_grant;
        end
    endtask

    initial begin
        test_reset();
        test_hiscore();
        test_timeout();
        test_osd();
        test_grant_follow();
        test_abort();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
